// File: rtl/instr_fetch_if.sv
// instr_fetch_if: fetch unit bus (imem request/response, instruction output, redirect)
//    master: the fetch unit; slave: instruction memory plus decode consumer
interface instr_fetch_if;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [6:0]  op;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic        redirect;
   logic [31:0] redirect_pc;
   modport master (
      output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, op, funct3, funct7b5,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect, redirect_pc
   );
   modport slave (
      input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, op, funct3, funct7b5,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: fetch PC, one-outstanding imem requests, 2-entry instruction FIFO, redirect flush
//    clk, reset_n (async, active low); bus: instr_fetch_if.master carrying imem req/rsp,
//    instr_valid/ready/instr/instr_pc/op/funct3/funct7b5 and redirect/redirect_pc
module instr_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic          clk,
   input logic          reset_n,
   instr_fetch_if.master bus
);
   typedef enum logic [1:0] {REQ, WAIT, DRAIN} state_t;
   state_t      state, nxt;
   logic [31:0] fetch_pc, tag;
   logic [31:0] word_q [2];
   logic [31:0] pc_q [2];
   logic [1:0]  count;
   logic        accept, push, pop, wr_idx;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= REQ;
      else state <= nxt;
   always_comb
      nxt = state == REQ  ? (accept ? (bus.redirect ? DRAIN : WAIT) : REQ) :
            state == WAIT ? (bus.imem_rsp_valid ? REQ : bus.redirect ? DRAIN : WAIT) :
                            (bus.imem_rsp_valid ? REQ : DRAIN);
   always_comb begin
      bus.imem_req_valid = reset_n && state == REQ && count != 2'd2;
      bus.imem_req_addr  = fetch_pc;
      accept = bus.imem_req_valid && bus.imem_req_ready;
      push   = state == WAIT && bus.imem_rsp_valid && !bus.redirect;
      pop    = bus.instr_ready && count != 2'd0;
      // slot for the new word after an optional same-cycle pop: count - pop (never 2 when pushing)
      wr_idx = count[0] ^ pop;
      bus.instr_valid = count != 2'd0;
      bus.instr       = bus.instr_valid ? word_q[0] : '0;
      bus.instr_pc    = bus.instr_valid ? pc_q[0] : '0;
      bus.op          = bus.instr[6:0];
      bus.funct3      = bus.instr[14:12];
      bus.funct7b5    = bus.instr[30];
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         fetch_pc <= RESET_PC;
         tag      <= '0;
         count    <= '0;
         word_q   <= '{default: '0};
         pc_q     <= '{default: '0};
      end else begin
         fetch_pc <= bus.redirect ? {bus.redirect_pc[31:2], 2'b00} : accept ? fetch_pc + 32'd4 : fetch_pc;
         if (accept) tag <= fetch_pc;
         count <= bus.redirect ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
         if (pop) begin
            word_q[0] <= word_q[1];
            pc_q[0]   <= pc_q[1];
         end
         if (push) begin
            word_q[wr_idx] <= bus.imem_rsp_data;
            pc_q[wr_idx]   <= tag;
         end
      end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vector table, wrap/async-reset sequence, randomized run vs queue model
module tb_instr_fetch;
   localparam bit H = 1'b1, L = 1'b0;
   logic clk = 0, rst_n = 0, rst_w = 0;
   always #5 clk = ~clk;
   instr_fetch_if bus();
   instr_fetch_if wbus();
   instr_fetch #(.RESET_PC(32'h0000_0100)) u_dut  (.clk(clk), .reset_n(rst_n), .bus(bus));
   instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (.clk(clk), .reset_n(rst_w), .bus(wbus));
   int n_cmp = 0, n_bad = 0;
   typedef struct {
      logic rdy, rsp; logic [31:0] rdata; logic ird, redir; logic [31:0] rpc;
      logic e_rv; logic [31:0] e_addr; logic e_iv; logic [31:0] e_ins, e_pc;
   } vec_t;
   typedef struct { logic [31:0] w, p; } ent_t;
   vec_t tbl[$];
   ent_t q[$];
   logic [31:0] mpc, mtag;
   bit busy, discard;
   function automatic vec_t v(logic rdy, rsp, logic [31:0] rdata, logic ird, redir, logic [31:0] rpc,
                              logic e_rv, logic [31:0] e_addr, logic e_iv, logic [31:0] e_ins, e_pc);
      v = '{rdy, rsp, rdata, ird, redir, rpc, e_rv, e_addr, e_iv, e_ins, e_pc};
   endfunction
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic chk_main(string nm, logic e_rv, logic [31:0] e_addr, logic e_iv, logic [31:0] e_ins, e_pc);
      chk({nm, ".req_valid"}, 32'(bus.imem_req_valid), 32'(e_rv));
      chk({nm, ".req_addr"}, bus.imem_req_addr, e_addr);
      chk({nm, ".instr_valid"}, 32'(bus.instr_valid), 32'(e_iv));
      chk({nm, ".instr"}, bus.instr, e_ins);
      chk({nm, ".instr_pc"}, bus.instr_pc, e_pc);
      chk({nm, ".op"}, 32'(bus.op), 32'(e_ins[6:0]));
      chk({nm, ".funct3"}, 32'(bus.funct3), 32'(e_ins[14:12]));
      chk({nm, ".funct7b5"}, 32'(bus.funct7b5), 32'(e_ins[30]));
   endtask
   task automatic drive(logic rdy, rsp, logic [31:0] rdata, logic ird, redir, logic [31:0] rpc);
      bus.imem_req_ready = rdy;
      bus.imem_rsp_valid = rsp;
      bus.imem_rsp_data  = rdata;
      bus.instr_ready    = ird;
      bus.redirect       = redir;
      bus.redirect_pc    = rpc;
   endtask
   // one model cycle: outputs from the current queue/flags, then apply this cycle's inputs
   task automatic model_cycle(string nm);
      bit m_rv, m_iv, acc;
      logic [31:0] m_ins, m_pc;
      m_rv  = !busy && q.size() < 2;
      m_iv  = q.size() > 0;
      m_ins = 0;
      m_pc  = 0;
      if (m_iv) begin
         m_ins = q[0].w;
         m_pc  = q[0].p;
      end
      chk_main(nm, m_rv, mpc, m_iv, m_ins, m_pc);
      acc = m_rv && bus.imem_req_ready;
      if (bus.redirect) begin
         q.delete();
         mpc     = {bus.redirect_pc[31:2], 2'b00};
         busy    = acc || (busy && !bus.imem_rsp_valid);
         discard = busy;
      end else begin
         if (bus.instr_ready && q.size() > 0) void'(q.pop_front());
         if (busy && bus.imem_rsp_valid) begin
            if (!discard) q.push_back('{bus.imem_rsp_data, mtag});
            busy    = 0;
            discard = 0;
         end
         if (acc) begin
            busy = 1;
            mtag = mpc;
            mpc  = mpc + 32'd4;
         end
      end
   endtask
   initial begin
      drive(L, L, 0, L, L, 0);
      wbus.imem_req_ready = 0; wbus.imem_rsp_valid = 0; wbus.imem_rsp_data = 0;
      wbus.instr_ready = 0; wbus.redirect = 0; wbus.redirect_pc = 0;
      tbl.push_back(v(H, L, 0,            L, L, 0,     H, 32'h100, L, 0,            0));
      tbl.push_back(v(L, H, 32'h00500093, L, L, 0,     L, 32'h104, L, 0,            0));
      tbl.push_back(v(L, L, 0,            L, L, 0,     H, 32'h104, H, 32'h00500093, 32'h100));
      tbl.push_back(v(L, L, 0,            L, L, 0,     H, 32'h104, H, 32'h00500093, 32'h100));
      tbl.push_back(v(L, L, 0,            L, L, 0,     H, 32'h104, H, 32'h00500093, 32'h100));
      tbl.push_back(v(H, L, 0,            L, L, 0,     H, 32'h104, H, 32'h00500093, 32'h100));
      tbl.push_back(v(H, H, 32'h40208133, L, L, 0,     L, 32'h108, H, 32'h00500093, 32'h100));
      tbl.push_back(v(H, L, 0,            L, L, 0,     L, 32'h108, H, 32'h00500093, 32'h100));
      tbl.push_back(v(H, L, 0,            H, L, 0,     L, 32'h108, H, 32'h00500093, 32'h100));
      tbl.push_back(v(H, L, 0,            H, L, 0,     H, 32'h108, H, 32'h40208133, 32'h104));
      tbl.push_back(v(H, L, 0,            L, H, 32'h203, L, 32'h10C, L, 0,          0));
      tbl.push_back(v(H, H, 32'hDEADBEEF, L, L, 0,     L, 32'h200, L, 0,            0));
      tbl.push_back(v(H, L, 0,            H, L, 0,     H, 32'h200, L, 0,            0));
      tbl.push_back(v(H, H, 32'h00A00113, L, L, 0,     L, 32'h204, L, 0,            0));
      tbl.push_back(v(H, L, 0,            H, L, 0,     H, 32'h204, H, 32'h00A00113, 32'h200));
      tbl.push_back(v(H, H, 32'h11111111, L, H, 32'h300, L, 32'h208, L, 0,          0));
      tbl.push_back(v(H, L, 0,            L, H, 32'h300, H, 32'h300, L, 0,          0));
      tbl.push_back(v(H, L, 0,            L, L, 0,     L, 32'h300, L, 0,            0));
      tbl.push_back(v(H, H, 32'h22222222, L, L, 0,     L, 32'h300, L, 0,            0));
      tbl.push_back(v(H, L, 0,            L, L, 0,     H, 32'h300, L, 0,            0));
      tbl.push_back(v(H, H, 32'h00C00193, L, L, 0,     L, 32'h304, L, 0,            0));
      tbl.push_back(v(L, H, 32'h33333333, L, L, 0,     H, 32'h304, H, 32'h00C00193, 32'h300));
      tbl.push_back(v(L, L, 0,            H, H, 32'h500, H, 32'h304, H, 32'h00C00193, 32'h300));
      tbl.push_back(v(L, L, 0,            L, L, 0,     H, 32'h500, L, 0,            0));
      @(negedge clk);
      chk_main("reset", L, 32'h100, L, 0, 0);
      @(posedge clk); #1 rst_n = 1;
      foreach (tbl[i]) begin
         drive(tbl[i].rdy, tbl[i].rsp, tbl[i].rdata, tbl[i].ird, tbl[i].redir, tbl[i].rpc);
         @(negedge clk);
         chk_main($sformatf("vec%0d", i), tbl[i].e_rv, tbl[i].e_addr, tbl[i].e_iv, tbl[i].e_ins, tbl[i].e_pc);
         @(posedge clk); #1;
      end
      rst_w = 1;
      wbus.imem_req_ready = 1;
      @(negedge clk);
      chk("wrap.rv0", 32'(wbus.imem_req_valid), 1);
      chk("wrap.addr0", wbus.imem_req_addr, 32'hFFFF_FFFC);
      @(posedge clk); #1 wbus.imem_rsp_valid = 1; wbus.imem_rsp_data = 32'h00500093;
      @(negedge clk);
      chk("wrap.rv1", 32'(wbus.imem_req_valid), 0);
      chk("wrap.addr1", wbus.imem_req_addr, 32'h0);
      @(posedge clk); #1 wbus.imem_rsp_valid = 0;
      @(negedge clk);
      chk("wrap.rv2", 32'(wbus.imem_req_valid), 1);
      chk("wrap.addr2", wbus.imem_req_addr, 32'h0);
      chk("wrap.iv2", 32'(wbus.instr_valid), 1);
      chk("wrap.ipc2", wbus.instr_pc, 32'hFFFF_FFFC);
      @(posedge clk); #1 wbus.imem_req_ready = 0;
      #2 rst_w = 0;
      #1;
      chk("arst.rv", 32'(wbus.imem_req_valid), 0);
      chk("arst.addr", wbus.imem_req_addr, 32'hFFFF_FFFC);
      chk("arst.iv", 32'(wbus.instr_valid), 0);
      chk("arst.instr", wbus.instr, 0);
      chk("arst.ipc", wbus.instr_pc, 0);
      chk("arst.fields", {wbus.op, wbus.funct3, wbus.funct7b5}, 0);
      @(posedge clk); #1 rst_w = 1; wbus.imem_rsp_valid = 1; wbus.imem_rsp_data = 32'h12345678;
      @(negedge clk);
      chk("spur.rv", 32'(wbus.imem_req_valid), 1);
      @(posedge clk); #1 wbus.imem_rsp_valid = 0;
      @(negedge clk);
      chk("spur.iv", 32'(wbus.instr_valid), 0);
      @(posedge clk); #1 rst_n = 0;
      drive(L, L, 0, L, L, 0);
      q.delete(); mpc = 32'h100; mtag = 0; busy = 0; discard = 0;
      @(posedge clk); #1 rst_n = 1;
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(3) != 0,
               busy ? $urandom_range(2) == 0 : $urandom_range(7) == 0,
               $urandom, 1'($urandom_range(1)), $urandom_range(15) == 0, $urandom);
         @(negedge clk);
         model_cycle("rnd");
         @(posedge clk); #1;
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
